ntt_butterfly: RTL and testbench

Pipelined modular butterfly for a dual-scheme lattice-crypto NTT datapath.
- Supports Kyber (q = 3329) and Dilithium (q = 8380417), selected per operation.
- Performs either the forward Cooley-Tukey (CT) butterfly or the inverse Gentleman-Sande (GS) butterfly.
- Sits between the coefficient memory read ports and write-back inside the NTT/INTT engine.

---
 rtl/ntt_pkg.sv | 76 +++++++
 rtl/ntt_butterfly_mod_mul.sv | 49 ++++
 rtl/ntt_butterfly.sv | 92 +++++++++
 tb/tb_ntt_butterfly.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared moduli, Barrett constants and modular helpers for the NTT butterfly.
// BUTTERFLY_GS_HALVE_EN adds the halving helper used by GS mode.
package ntt_pkg;

  localparam int unsigned CW = 23;
  localparam int unsigned PW = 2 * CW;
  localparam int unsigned MW = 24;

  localparam logic [CW-1:0] Q_KYBER     = 23'd3329;
  localparam logic [CW-1:0] Q_DILITHIUM = 23'd8380417;

  localparam int unsigned K_KYBER     = 24;
  localparam int unsigned K_DILITHIUM = 46;

  localparam logic [MW-1:0] M_KYBER =
    MW'((64'd1 << K_KYBER) / 64'(Q_KYBER));
  localparam logic [MW-1:0] M_DILITHIUM =
    MW'((64'd1 << K_DILITHIUM) / 64'(Q_DILITHIUM));

  typedef enum logic {
    MODE_DILITHIUM = 1'b0,
    MODE_KYBER     = 1'b1
  } mode_e;

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_e;

  typedef struct packed {
    logic          valid;
    mode_e         mode;
    bf_e           bf;
    logic [CW-1:0] lhs;
  } bf_stage_t;

  function automatic logic [CW-1:0] q_of(mode_e m);
    return (m == MODE_KYBER) ? Q_KYBER : Q_DILITHIUM;
  endfunction

  function automatic logic [CW-1:0] norm(
    logic [CW:0]   x,
    logic [CW-1:0] q
  );
    return (x >= {1'b0, q}) ? CW'(x - {1'b0, q}) : x[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] add_mod(
    logic [CW-1:0] x,
    logic [CW-1:0] y,
    logic [CW-1:0] q
  );
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, q}) ? CW'(s - {1'b0, q}) : s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] sub_mod(
    logic [CW-1:0] x,
    logic [CW-1:0] y,
    logic [CW-1:0] q
  );
    return (x < y) ? x - y + q : x - y;
  endfunction

`ifdef BUTTERFLY_GS_HALVE_EN
  // x * 2^-1 mod q for odd q
  function automatic logic [CW-1:0] halve(
    logic [CW-1:0] x,
    logic [CW-1:0] q
  );
    return x[0] ? CW'(({1'b0, x} + {1'b0, q}) >> 1) : (x >> 1);
  endfunction
`endif

endpackage

// File: rtl/ntt_butterfly_mod_mul.sv
// Registered 23x23 multiply followed by registered Barrett reduction.
// Two cycles from operands to canonical residue.
module mod_mul
  import ntt_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  mode_e         mode_i,
  output logic [CW-1:0] r_o
);

  localparam int unsigned EW = PW + MW;
  localparam int unsigned RW = CW + 2;

  logic [PW-1:0] prod_q;
  mode_e         mode_q;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] q, qh;
  logic [RW-1:0] r0, r1;

  always_comb begin
    q = q_of(mode_q);
    if (mode_q == MODE_KYBER)
      qh = CW'((EW'(prod_q[K_KYBER-1:0]) * EW'(M_KYBER)) >> K_KYBER);
    else
      qh = CW'((EW'(prod_q) * EW'(M_DILITHIUM)) >> K_DILITHIUM);
    // estimate undershoots by at most 2q
    r0  = RW'(prod_q - PW'(qh) * PW'(q));
    r1  = (r0 >= RW'(q)) ? r0 - RW'(q) : r0;
    r_d = (r1 >= RW'(q)) ? CW'(r1 - RW'(q)) : CW'(r1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prod_q <= '0;
      mode_q <= MODE_DILITHIUM;
      r_q    <= '0;
    end else begin
      prod_q <= PW'(x_i) * PW'(y_i);
      mode_q <= mode_i;
      r_q    <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined Kyber/Dilithium CT/GS butterfly, 3-cycle latency.
// Define BUTTERFLY_GS_HALVE_EN to fold 2^-1 scaling into GS outputs.
module ntt_butterfly
  import ntt_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          valid_i,
  input  logic [CW:0]   a_i,
  input  logic [CW:0]   b_i,
  input  logic [CW-1:0] twiddle_i,
  input  logic          sel_red_i,
  input  logic          sel_butterfly_i,
  output logic          valid_o,
  output logic [CW-1:0] a_out_o,
  output logic [CW-1:0] b_out_o
);

  bf_stage_t     st1_d, st1_q, st2_q, st3_q;
  logic [CW-1:0] q_in, an, bn;
  logic [CW-1:0] x_d, x_q, w_q, t;
  logic [CW-1:0] q3, a_d, b_d, a_q, b_q;
  logic          valid_q;

  // CT multiplies b; GS multiplies (a - b) and keeps (a + b)
  always_comb begin
    q_in        = q_of(mode_e'(sel_red_i));
    an          = norm(a_i, q_in);
    bn          = norm(b_i, q_in);
    st1_d.valid = valid_i;
    st1_d.mode  = mode_e'(sel_red_i);
    st1_d.bf    = bf_e'(sel_butterfly_i);
    st1_d.lhs   = sel_butterfly_i ? add_mod(an, bn, q_in) : an;
    x_d         = sel_butterfly_i ? sub_mod(an, bn, q_in) : bn;
  end

  mod_mul u_mul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .x_i     (x_q),
    .y_i     (w_q),
    .mode_i  (st1_q.mode),
    .r_o     (t)
  );

  always_comb begin
    q3  = q_of(st3_q.mode);
    a_d = a_q;
    b_d = b_q;
    if (st3_q.valid) begin
      if (st3_q.bf == BF_CT) begin
        a_d = add_mod(st3_q.lhs, t, q3);
        b_d = sub_mod(st3_q.lhs, t, q3);
      end else begin
`ifdef BUTTERFLY_GS_HALVE_EN
        a_d = halve(st3_q.lhs, q3);
        b_d = halve(t, q3);
`else
        a_d = st3_q.lhs;
        b_d = t;
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      st1_q   <= '0;
      st2_q   <= '0;
      st3_q   <= '0;
      x_q     <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      st1_q   <= st1_d;
      x_q     <= x_d;
      w_q     <= twiddle_i;
      st2_q   <= st1_q;
      st3_q   <= st2_q;
      valid_q <= st3_q.valid;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign valid_o = valid_q;
  assign a_out_o = a_q;
  assign b_out_o = b_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// Self-checking bench for ntt_butterfly: directed table, reset
// sequence and randomized traffic against an arithmetic model.
`timescale 1ns/1ps
module tb_ntt_butterfly;

  localparam longint QK = 3329;
  localparam longint QD = 8380417;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [23:0] a_i = '0;
  logic [23:0] b_i = '0;
  logic [22:0] w_i = '0;
  logic        sel_red = 1'b0;
  logic        sel_bf = 1'b0;
  logic        valid_o;
  logic [22:0] a_out;
  logic [22:0] b_out;

  typedef struct {
    longint ea;
    longint eb;
    int     due;
  } exp_t;

  typedef struct {
    longint a;
    longint b;
    longint w;
    bit     kyb;
    bit     gs;
    longint ea;
    longint eb;
  } vec_t;

  exp_t   exq[$];
  vec_t   tbl[$];
  longint cur_ea = 0;
  longint cur_eb = 0;
  longint last_a = 0;
  longint last_b = 0;
  bit     armed = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;

  always #5 clk = ~clk;

  ntt_butterfly dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .valid_i         (valid_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .twiddle_i       (w_i),
    .sel_red_i       (sel_red),
    .sel_butterfly_i (sel_bf),
    .valid_o         (valid_o),
    .a_out_o         (a_out),
    .b_out_o         (b_out)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint gs_adj(longint x, longint q);
`ifdef BUTTERFLY_GS_HALVE_EN
    return (x % 2 != 0) ? (x + q) / 2 : x / 2;
`else
    return x + 0 * q;
`endif
  endfunction

  task automatic model(input longint a, input longint b, input longint w,
                       input bit kyb, input bit gs,
                       output longint ea, output longint eb);
    longint q, an, bn, t;
    q  = kyb ? QK : QD;
    an = a % q;
    bn = b % q;
    if (!gs) begin
      t  = (bn * w) % q;
      ea = (an + t) % q;
      eb = (an - t + q) % q;
    end else begin
      ea = gs_adj((an + bn) % q, q);
      eb = gs_adj((((an - bn + q) % q) * w) % q, q);
    end
  endtask

  task automatic drive(input longint a, input longint b, input longint w,
                       input bit kyb, input bit gs,
                       input longint ea, input longint eb, input bit v);
    @(negedge clk);
    valid_i = v;
    a_i     = 24'(a);
    b_i     = 24'(b);
    w_i     = 23'(w);
    sel_red = kyb;
    sel_bf  = gs;
    cur_ea  = ea;
    cur_eb  = eb;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  // Accepted operations are due three edges after the accepting edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) exq.delete();
    else if (valid_i) exq.push_back('{cur_ea, cur_eb, cyc + 4});
  end

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_a", 64'(a_out), 64'd0);
      check("rst_b", 64'(b_out), 64'd0);
      last_a = 0;
      last_b = 0;
      armed  = 1'b1;
    end else if (valid_o === 1'b1) begin
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = exq.pop_front();
        check("latency", 64'(cyc), 64'(e.due));
        check("a_out", 64'(a_out), 64'(e.ea));
        check("b_out", 64'(b_out), 64'(e.eb));
        last_a = e.ea;
        last_b = e.eb;
      end
    end else begin
      if (exq.size() > 0 && exq[0].due <= cyc) begin
        e = exq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_valid actual=0 required=1 due=%0d", e.due);
      end
      if (armed) begin
        check("hold_a", 64'(a_out), 64'(last_a));
        check("hold_b", 64'(b_out), 64'(last_b));
      end
    end
  end

  initial begin
    longint a, b, w, q, ea, eb;
    bit kyb, gs;

    tbl = '{
      '{3210, 19, 281, 1'b1, 1'b0, 1891, 1200},
      '{1891, 1200, 281, 1'b1, 1'b1, 3091, 1089},
      '{8297430, 7194, 400232, 1'b0, 1'b0, 4702990, 3511453},
      '{4702990, 3511453, 400232, 1'b0, 1'b1, 8214443, 3607199},
      '{3328, 3328, 1, 1'b1, 1'b0, 3327, 0},
      '{3334, 0, 7, 1'b1, 1'b0, 5, 5},
      '{0, 0, 5, 1'b1, 1'b0, 0, 0},
      '{8380416, 8380416, 1, 1'b0, 1'b0, 8380415, 0},
      '{1234, 999, 0, 1'b1, 1'b0, 1234, 1234},
      '{100, 200, 1, 1'b1, 1'b1, 300, 3229},
      '{0, 0, 77, 1'b0, 1'b1, 0, 0},
      '{5, 3, 1, 1'b0, 1'b1, 8, 2}
    };

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // directed vectors issued back to back
    for (int i = 0; i < tbl.size(); i++) begin
      q  = tbl[i].kyb ? QK : QD;
      ea = tbl[i].gs ? gs_adj(tbl[i].ea, q) : tbl[i].ea;
      eb = tbl[i].gs ? gs_adj(tbl[i].eb, q) : tbl[i].eb;
      drive(tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].kyb, tbl[i].gs,
            ea, eb, 1'b1);
    end
    idle(6);

    // reset with two operations in flight
    drive(tbl[0].a, tbl[0].b, tbl[0].w, 1'b1, 1'b0, 1891, 1200, 1'b1);
    drive(tbl[2].a, tbl[2].b, tbl[2].w, 1'b0, 1'b0, 4702990, 3511453, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // randomized mixed traffic
    for (int i = 0; i < 400; i++) begin
      kyb = 1'($urandom_range(0, 1));
      gs  = 1'($urandom_range(0, 1));
      q   = kyb ? QK : QD;
      a   = longint'($urandom_range(0, 32'(2 * q - 1)));
      b   = longint'($urandom_range(0, 32'(2 * q - 1)));
      w   = longint'($urandom_range(0, 32'(q - 1)));
      model(a, b, w, kyb, gs, ea, eb);
      drive(a, b, w, kyb, gs, ea, eb, $urandom_range(0, 3) != 0);
    end
    idle(1);

    for (int k = 0; k < 20 && exq.size() > 0; k++) @(negedge clk);
    if (exq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain actual=%0d required=0", exq.size());
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
